inst_feeder: RTL



---
 rtl/inst_feeder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/inst_feeder.sv
// inst_feeder: host-loaded instruction queue feeding minimips outer_inst/en.
// Define INST_FEEDER_LOOP_EN to turn the queue into replaying program memory.
module inst_feeder #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     cpu_clk_50M,
    input  logic                     cpu_rst,
    input  logic                     host_valid,
    input  logic [31:0]              host_inst,
    output logic                     host_ready,
    input  logic                     start,
    input  logic                     stop,
    output logic                     cpu_en,
    output logic [31:0]              outer_inst,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         issued_cnt
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;
    localparam logic [LVL_W-1:0] FULL  = LVL_W'(DEPTH);
    localparam logic [5:0]       OP_LW = 6'b100011;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        BUBBLE
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [31:0]       mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_d;
    logic [AW-1:0]     rd_d;
    logic [LVL_W-1:0]  level_d;
    logic [31:0]       head;
    logic [4:0]        lw_rt;
    logic [4:0]        lw_rt_d;
    logic              last_lw_valid;
    logic              lw_valid_d;
    logic              empty;
    logic              push;
    logic              active;
    logic              hazard;
    logic              issue;
    logic              ready_d;
    logic              cpu_en_d;
    logic [31:0]       outer_d;
    logic [CNT_W-1:0]  cnt_d;

    function automatic logic [31:0] bit_rev(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = w[31-i];
        end
        return r;
    endfunction

    always_comb begin
        head    = mem[rd_ptr];
        empty   = (fifo_level == '0);
        push    = host_valid && host_ready;
        // stop wins over start and over any pending hazard
        active  = !stop && ((state_q != IDLE) || start);
        hazard  = (state_q == RUN) && last_lw_valid
                  && (lw_rt != 5'd0) && !empty
                  && ((head[25:21] == lw_rt) || (head[20:16] == lw_rt));
        issue   = active && !hazard && !empty;

        state_d = state_q;
        if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN:     if (hazard) state_d = BUBBLE;
                BUBBLE:  state_d = RUN;
                default: state_d = IDLE;
            endcase
        end

        cpu_en_d   = active;
        outer_d    = issue ? bit_rev(head) : 32'h0;
        cnt_d      = issue ? issued_cnt + CNT_W'(1) : issued_cnt;
        lw_valid_d = issue && (head[31:26] == OP_LW);
        lw_rt_d    = lw_valid_d ? head[20:16] : lw_rt;
        wr_d       = push ? wr_ptr + AW'(1) : wr_ptr;

`ifdef INST_FEEDER_LOOP_EN
        // entries are never consumed; read index wraps after last loaded word
        level_d = fifo_level + LVL_W'(push);
        rd_d    = rd_ptr;
        if (issue) begin
            if (LVL_W'(rd_ptr) == fifo_level - LVL_W'(1))
                rd_d = '0;
            else
                rd_d = rd_ptr + AW'(1);
        end
        ready_d = (state_d == IDLE) && (level_d != FULL);
`else
        level_d = fifo_level + LVL_W'(push) - LVL_W'(issue);
        rd_d    = issue ? rd_ptr + AW'(1) : rd_ptr;
        ready_d = (level_d != FULL);
`endif
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (push) begin
            mem[wr_ptr] <= host_inst;
        end
    end

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q       <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_level    <= '0;
            host_ready    <= 1'b1;
            cpu_en        <= 1'b0;
            outer_inst    <= 32'h0;
            busy          <= 1'b0;
            issued_cnt    <= '0;
            lw_rt         <= 5'd0;
            last_lw_valid <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr        <= wr_d;
            rd_ptr        <= rd_d;
            fifo_level    <= level_d;
            host_ready    <= ready_d;
            cpu_en        <= cpu_en_d;
            outer_inst    <= outer_d;
            busy          <= (state_d != IDLE);
            issued_cnt    <= cnt_d;
            lw_rt         <= lw_rt_d;
            last_lw_valid <= lw_valid_d;
        end
    end

endmodule
